addr_seq_ctrl: RTL and testbench
================================

# addr_seq_ctrl

Sequencing controller for the 2-D strided address generator. It accepts a one-shot scan configuration (offset, x extent/stride, y extent/stride) and walks the full x-inner / y-outer scan. It emits one address per accepted transfer on a valid/ready stream, and signals completion. It replaces the free-running scan counters with a start/stop-able, backpressure-aware, bounded scan for use by memory-side consumers.

## Interface
Parameters:
- WIDTH, 16, width of all address, extent and stride fields.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  controller can accept a configuration; high exactly in IDLE.
- cfg_offset  in  WIDTH  base address.
- cfg_x_max  in  WIDTH  inner extent (addresses per row).
- cfg_x_stride  in  WIDTH  inner increment.
- cfg_y_max  in  WIDTH  outer extent (rows).
- cfg_y_stride  in  WIDTH  outer increment.
- abort  in  1  terminate the current scan.
- addr_valid  out  1  addr is valid.
- addr_ready  in  1  consumer accepts addr.
- addr  out  WIDTH  current address.
- addr_last  out  1  addr is the final address of the scan.
- busy  out  1  scan in progress (RUN).
- done  out  1  one-cycle pulse after the final address is accepted.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: cfg_ready=1.
  - On cfg_valid&&cfg_ready, latch all cfg_* fields and clear x_cnt, y_cnt, x_acc and y_acc.
  - If either latched extent is 0, go to DONE; otherwise go to RUN.
  - cfg_* fields are ignored outside the accept cycle.
- RUN: addr_valid=1, busy=1.
  - addr = offset + x_acc + y_acc, all modulo 2^WIDTH, taken from registered state only.
  - addr_last = (x_cnt==x_max-1)&&(y_cnt==y_max-1).
- Handshake (addr_valid&&addr_ready, abort=0):
  - Not at end of row: x_cnt+=1, x_acc+=x_stride.
  - End of row (x_cnt==x_max-1): x_cnt=0, x_acc=0, y_cnt+=1, y_acc+=y_stride.
  - Handshake with addr_last set: go to DONE.
- No handshake: all counters and addr hold. addr and addr_last stay stable while addr_valid && !addr_ready.
- DONE: done=1 for exactly one cycle, cfg_ready=0, then go to IDLE.
- abort in RUN: go to IDLE next cycle. No done pulse. Counters are not required to hold any value.
  - Abort takes priority over a same-cycle handshake; that address counts as not delivered.
  - abort in IDLE or DONE is ignored.
- Extents are unsigned. Strides are added modulo 2^WIDTH, so any negative stride is expressed in two's complement.
- Reset (asynchronous, any state, including mid-scan): state=IDLE and all registers cleared.
  - addr_valid=0, addr=0, addr_last=0, busy=0, done=0, cfg_ready=1.
  - Any scan in flight is discarded.

## Timing
- Config accepted at edge T: addr_valid=1 with addr=cfg_offset in cycle T+1.
- Throughput: 1 address/cycle while addr_ready=1; no bubbles at row boundaries.
- Scan of x_max*y_max addresses with addr_ready always 1: addresses in cycles T+1 .. T+x_max*y_max.
- Final handshake in cycle N: done=1 in cycle N+1 and addr_valid=0 in N+1; cfg_ready=1 in N+2.
  - Earliest next config accept is N+2.
- Zero extent accepted at T: done=1 in T+1, no addr_valid ever asserted.
- abort in cycle A during RUN: addr_valid=0 and cfg_ready=1 in A+1.
- No combinational path from addr_ready, cfg_valid or abort to any output.

## Test plan
- Basic scan. Stimulus: offset=100, x_max=3, x_stride=2, y_max=2, y_stride=10, addr_ready=1.
  - Required: addr 100,102,104,110,112,114 on consecutive cycles.
  - addr_last only on 114; done one cycle later; cfg_ready two cycles later.
- Backpressure. Same config; drop addr_ready for 3 cycles while addr=102, plus random ready toggling afterwards.
  - Required: 102 held stable with addr_valid=1 throughout the stall.
  - Full sequence unchanged, no duplicates or drops.
- Zero extent. x_max=0 (then separately y_max=0).
  - Required: no addr_valid; done pulse in the cycle after accept.
- Wrap-around. offset=0xFFFF, x_max=2, x_stride=1, y_max=2, y_stride=0xFFFE.
  - Required: addr 0xFFFF, 0x0000, 0xFFFD, 0xFFFE; addr_last on 0xFFFE.
- Abort. Assert abort in the same cycle as the handshake of the 4th address in the basic scan.
  - Required: addr_valid=0 and cfg_ready=1 next cycle; no done.
  - A new config then starts cleanly from its own offset.
- Reset mid-scan. Assert rst_n=0 asynchronously, between edges, while addr=110.
  - Required: outputs go to their reset values immediately (cfg_ready=1, all others 0).
  - After release, the scan resumes only after a new config.

Source files
------------

// File: rtl/addr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : addr_seq_ctrl
// Description : Bounded 2-D strided address sequencer. Walks x-inner/y-outer
//               on a valid/ready stream and pulses done at the end.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_offset,
    input  logic [WIDTH-1:0] cfg_x_max,
    input  logic [WIDTH-1:0] cfg_x_stride,
    input  logic [WIDTH-1:0] cfg_y_max,
    input  logic [WIDTH-1:0] cfg_y_stride,
    input  logic             abort,
    output logic             addr_valid,
    input  logic             addr_ready,
    output logic [WIDTH-1:0] addr,
    output logic             addr_last,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] offset_q,   offset_d;
    logic [WIDTH-1:0] x_max_q,    x_max_d;
    logic [WIDTH-1:0] x_stride_q, x_stride_d;
    logic [WIDTH-1:0] y_max_q,    y_max_d;
    logic [WIDTH-1:0] y_stride_q, y_stride_d;
    logic [WIDTH-1:0] x_cnt_q,    x_cnt_d;
    logic [WIDTH-1:0] y_cnt_q,    y_cnt_d;
    logic [WIDTH-1:0] x_acc_q,    x_acc_d;
    logic [WIDTH-1:0] y_acc_q,    y_acc_d;

    logic w_run;
    logic w_x_end;
    logic w_y_end;

    assign w_run   = (state_q == C_ST_RUN);
    assign w_x_end = (x_cnt_q == x_max_q - WIDTH'(1));
    assign w_y_end = (y_cnt_q == y_max_q - WIDTH'(1));

    // Outputs are decoded from registered state only; addr is forced to zero
    // outside RUN so idle/reset presents a clean bus.
    assign cfg_ready  = (state_q == C_ST_IDLE);
    assign addr_valid = w_run;
    assign busy       = w_run;
    assign done       = (state_q == C_ST_DONE);
    assign addr_last  = w_run && w_x_end && w_y_end;
    assign addr       = w_run ? (offset_q + x_acc_q + y_acc_q) : '0;

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        x_max_d    = x_max_q;
        x_stride_d = x_stride_q;
        y_max_d    = y_max_q;
        y_stride_d = y_stride_q;
        x_cnt_d    = x_cnt_q;
        y_cnt_d    = y_cnt_q;
        x_acc_d    = x_acc_q;
        y_acc_d    = y_acc_q;

        case (state_q)
            C_ST_IDLE: begin
                if (cfg_valid) begin
                    offset_d   = cfg_offset;
                    x_max_d    = cfg_x_max;
                    x_stride_d = cfg_x_stride;
                    y_max_d    = cfg_y_max;
                    y_stride_d = cfg_y_stride;
                    x_cnt_d    = '0;
                    y_cnt_d    = '0;
                    x_acc_d    = '0;
                    y_acc_d    = '0;
                    if ((cfg_x_max == '0) || (cfg_y_max == '0)) begin
                        state_d = C_ST_DONE;
                    end else begin
                        state_d = C_ST_RUN;
                    end
                end
            end
            C_ST_RUN: begin
                // Abort wins over a same-cycle handshake.
                if (abort) begin
                    state_d = C_ST_IDLE;
                end else if (addr_ready) begin
                    if (w_x_end) begin
                        x_cnt_d = '0;
                        x_acc_d = '0;
                        y_cnt_d = y_cnt_q + WIDTH'(1);
                        y_acc_d = y_acc_q + y_stride_q;
                    end else begin
                        x_cnt_d = x_cnt_q + WIDTH'(1);
                        x_acc_d = x_acc_q + x_stride_q;
                    end
                    if (w_x_end && w_y_end) begin
                        state_d = C_ST_DONE;
                    end
                end
            end
            C_ST_DONE: begin
                state_d = C_ST_IDLE;
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= C_ST_IDLE;
            offset_q   <= '0;
            x_max_q    <= '0;
            x_stride_q <= '0;
            y_max_q    <= '0;
            y_stride_q <= '0;
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            x_acc_q    <= '0;
            y_acc_q    <= '0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            x_max_q    <= x_max_d;
            x_stride_q <= x_stride_d;
            y_max_q    <= y_max_d;
            y_stride_q <= y_stride_d;
            x_cnt_q    <= x_cnt_d;
            y_cnt_q    <= y_cnt_d;
            x_acc_q    <= x_acc_d;
            y_acc_q    <= y_acc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_seq_ctrl
// Description : Directed vector table plus hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_seq_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_offset;
    logic [WIDTH-1:0] cfg_x_max;
    logic [WIDTH-1:0] cfg_x_stride;
    logic [WIDTH-1:0] cfg_y_max;
    logic [WIDTH-1:0] cfg_y_stride;
    logic             abort;
    logic             addr_valid;
    logic             addr_ready;
    logic [WIDTH-1:0] addr;
    logic             addr_last;
    logic             busy;
    logic             done;

    addr_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_offset   (cfg_offset),
        .cfg_x_max    (cfg_x_max),
        .cfg_x_stride (cfg_x_stride),
        .cfg_y_max    (cfg_y_max),
        .cfg_y_stride (cfg_y_stride),
        .abort        (abort),
        .addr_valid   (addr_valid),
        .addr_ready   (addr_ready),
        .addr         (addr),
        .addr_last    (addr_last),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             cv;
        logic [WIDTH-1:0] off, xm, xs, ym, ys;
        logic             ab, rdy;
        logic             e_av;
        logic [WIDTH-1:0] e_addr;
        logic             e_last, e_busy, e_done, e_crdy;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
        else             n_pass++;
    endtask

    task automatic push(input logic cv, input logic [WIDTH-1:0] off, xm, xs, ym, ys,
                        input logic ab, rdy, e_av, input logic [WIDTH-1:0] e_addr,
                        input logic e_last, e_busy, e_done, e_crdy);
        vec_t v;
        v.cv = cv; v.off = off; v.xm = xm; v.xs = xs; v.ym = ym; v.ys = ys;
        v.ab = ab; v.rdy = rdy; v.e_av = e_av; v.e_addr = e_addr;
        v.e_last = e_last; v.e_busy = e_busy; v.e_done = e_done; v.e_crdy = e_crdy;
        vecs.push_back(v);
    endtask

    // Config offered in IDLE: outputs still show IDLE this cycle.
    task automatic add_cfg(input logic [WIDTH-1:0] off, xm, xs, ym, ys);
        push(1'b1, off, xm, xs, ym, ys, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask
    // Junk cfg fields driven with cfg_valid low must have no effect.
    task automatic add_run(input logic rdy, ab, input logic [WIDTH-1:0] a, input logic last);
        push(1'b0, 16'hDEAD, 16'h0007, 16'hBEEF, 16'h0009, 16'h1234, ab, rdy,
             1'b1, a, last, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic add_done();
        push(1'b0, 16'hDEAD, 16'h0007, 16'hBEEF, 16'h0009, 16'h1234, 1'b1, 1'b1,
             1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask
    task automatic add_idle(input logic ab);
        push(1'b0, 16'hDEAD, 16'h0007, 16'hBEEF, 16'h0009, 16'h1234, ab, 1'b1,
             1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drive(input vec_t v);
        cfg_valid = v.cv; cfg_offset = v.off; cfg_x_max = v.xm; cfg_x_stride = v.xs;
        cfg_y_max = v.ym; cfg_y_stride = v.ys; abort = v.ab; addr_ready = v.rdy;
    endtask

    task automatic drive_idle();
        cfg_valid = 1'b0; abort = 1'b0; addr_ready = 1'b0;
        cfg_offset = '0; cfg_x_max = '0; cfg_x_stride = '0; cfg_y_max = '0; cfg_y_stride = '0;
    endtask

    task automatic drive_cfg(input logic [WIDTH-1:0] off, xm, xs, ym, ys);
        cfg_valid = 1'b1; cfg_offset = off; cfg_x_max = xm; cfg_x_stride = xs;
        cfg_y_max = ym; cfg_y_stride = ys; abort = 1'b0; addr_ready = 1'b1;
    endtask

    logic [WIDTH-1:0] exp_basic [6];
    logic [WIDTH-1:0] got_q[$];
    logic [WIDTH-1:0] prev_addr;
    logic             prev_stall;
    bit               seen_done;

    initial begin
        exp_basic[0] = 16'd100; exp_basic[1] = 16'd102; exp_basic[2] = 16'd104;
        exp_basic[3] = 16'd110; exp_basic[4] = 16'd112; exp_basic[5] = 16'd114;

        // Basic scan, done one cycle after last, cfg_ready the cycle after.
        add_cfg(16'd100, 16'd3, 16'd2, 16'd2, 16'd10);
        add_run(1, 0, 16'd100, 0); add_run(1, 0, 16'd102, 0); add_run(1, 0, 16'd104, 0);
        add_run(1, 0, 16'd110, 0); add_run(1, 0, 16'd112, 0); add_run(1, 0, 16'd114, 1);
        add_done(); add_idle(1'b1);
        // Backpressure: three stall cycles on 102, then scattered stalls.
        add_cfg(16'd100, 16'd3, 16'd2, 16'd2, 16'd10);
        add_run(1, 0, 16'd100, 0);
        add_run(0, 0, 16'd102, 0); add_run(0, 0, 16'd102, 0); add_run(0, 0, 16'd102, 0);
        add_run(1, 0, 16'd102, 0); add_run(0, 0, 16'd104, 0); add_run(1, 0, 16'd104, 0);
        add_run(1, 0, 16'd110, 0); add_run(0, 0, 16'd112, 0); add_run(1, 0, 16'd112, 0);
        add_run(0, 0, 16'd114, 1); add_run(1, 0, 16'd114, 1);
        add_done(); add_idle(1'b0);
        // Wrap-around with a negative outer stride.
        add_cfg(16'hFFFF, 16'd2, 16'd1, 16'd2, 16'hFFFE);
        add_run(1, 0, 16'hFFFF, 0); add_run(1, 0, 16'h0000, 0);
        add_run(1, 0, 16'hFFFD, 0); add_run(1, 0, 16'hFFFE, 1);
        add_done(); add_idle(1'b0);
        // Zero extents: straight to DONE, never valid.
        add_cfg(16'd50, 16'd0, 16'd1, 16'd4, 16'd1);
        add_done(); add_idle(1'b0);
        add_cfg(16'd50, 16'd4, 16'd1, 16'd0, 16'd1);
        add_done(); add_idle(1'b0);
        // Abort on the 4th handshake: no done, then a clean fresh scan.
        add_cfg(16'd100, 16'd3, 16'd2, 16'd2, 16'd10);
        add_run(1, 0, 16'd100, 0); add_run(1, 0, 16'd102, 0); add_run(1, 0, 16'd104, 0);
        add_run(1, 1, 16'd110, 0);
        add_idle(1'b0);
        add_cfg(16'd5, 16'd1, 16'd7, 16'd2, 16'd3);
        add_run(1, 0, 16'd5, 0); add_run(1, 0, 16'd8, 1);
        add_done(); add_idle(1'b0);

        drive_idle();
        rst_n = 1'b0;
        #12;
        chk("reset_outputs", {cfg_ready, addr_valid, addr, addr_last, busy, done},
            {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {addr_valid, busy, done, cfg_ready, addr_last, (vecs[i].e_av ? addr : 16'h0)},
                {vecs[i].e_av, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_crdy,
                 vecs[i].e_last, vecs[i].e_addr});
        end

        // Random ready toggling: collect handshakes, check stall stability.
        @(posedge clk); #1;
        drive_cfg(16'd100, 16'd3, 16'd2, 16'd2, 16'd10);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        got_q.delete();
        prev_stall = 1'b0;
        prev_addr  = '0;
        seen_done  = 1'b0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            addr_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (prev_stall) chk("stall_hold", {addr_valid, addr}, {1'b1, prev_addr});
            prev_stall = addr_valid && !addr_ready;
            prev_addr  = addr;
            if (addr_valid && addr_ready) got_q.push_back(addr);
            @(posedge clk); #1;
        end
        chk("rand_done_seen", 64'(seen_done), 64'd1);
        chk("rand_count", 64'(got_q.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rand_addr%0d", k), (k < got_q.size()) ? 64'(got_q[k]) : 64'hX,
                64'(exp_basic[k]));
        end

        // Reset asserted between edges while addr=110.
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        drive_cfg(16'd100, 16'd3, 16'd2, 16'd2, 16'd10);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_addr", {addr_valid, addr}, {1'b1, 16'd110});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {cfg_ready, addr_valid, addr, addr_last, busy, done},
            {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_idle", {addr_valid, busy, cfg_ready}, {1'b0, 1'b0, 1'b1});
        end
        @(posedge clk); #1;
        drive_cfg(16'd40, 16'd2, 16'd1, 16'd1, 16'd0);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("restart_first", {addr_valid, addr}, {1'b1, 16'd40});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
